// File: rtl/phase_sequencer.sv
// Phase sequencer: steps through NUM_PHASES timed display phases driven by a
// shared tick strobe. Ports: clk, rst, tick, start, stop, pause, skip,
// cfg_we/cfg_idx/cfg_dur (duration regs), phase, remaining, busy, paused,
// phase_done, seq_done.
module phase_sequencer #(
  parameter int NUM_PHASES  = 4,
  parameter int IDX_W       = 2,
  parameter int CNT_W       = 8,
  parameter bit LOOP        = 1'b0,
  parameter int DEFAULT_DUR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             skip,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [CNT_W-1:0] cfg_dur,
  output logic [IDX_W-1:0] phase,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             paused,
  output logic             phase_done,
  output logic             seq_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_PHASES - 1);
  localparam logic [CNT_W-1:0] DDUR = CNT_W'(DEFAULT_DUR);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [IDX_W-1:0] phase_n;
  logic [IDX_W-1:0] phase_inc;
  logic [CNT_W-1:0] rem_n;
  logic             pd_n, sd_n;
  logic [CNT_W-1:0] dur [NUM_PHASES];
  logic             cfg_ok;

  assign phase_inc = phase + IDX_W'(1);
  assign cfg_ok    = cfg_we && (int'(cfg_idx) < NUM_PHASES);

  // Durations are only sampled at a load, so writes never disturb
  // the phase currently counting down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHASES; i++) dur[i] <= DDUR;
    end else if (cfg_ok) begin
      dur[cfg_idx] <= (cfg_dur == '0) ? ONE : cfg_dur;
    end
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    rem_n   = remaining;
    pd_n    = 1'b0;
    sd_n    = 1'b0;
    if (stop) begin
      state_n = IDLE;
      phase_n = '0;
      rem_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = RUN;
            phase_n = '0;
            rem_n   = dur[0];
          end
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (skip || (tick && remaining == ONE)) begin
            pd_n = 1'b1;
            if (phase == LAST) begin
              sd_n    = 1'b1;
              phase_n = '0;
              if (LOOP) begin
                rem_n = dur[0];
              end else begin
                state_n = IDLE;
                rem_n   = '0;
              end
            end else begin
              phase_n = phase_inc;
              rem_n   = dur[phase_inc];
            end
          end else if (tick) begin
            rem_n = remaining - ONE;
          end
        end
        PAUSED: begin
          if (!pause) state_n = RUN;
        end
        default: begin
          state_n = IDLE;
          phase_n = '0;
          rem_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      remaining  <= '0;
      busy       <= 1'b0;
      paused     <= 1'b0;
      phase_done <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      remaining  <= rem_n;
      busy       <= (state_n != IDLE);
      paused     <= (state_n == PAUSED);
      phase_done <= pd_n;
      seq_done   <= sd_n;
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: a LOOP=0 and a LOOP=1 instance
// share all inputs; expectations are hand-computed per step.
module tb_phase_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 0, start = 0, stop = 0, pause = 0, skip = 0;
  logic       cfg_we = 0;
  logic [1:0] cfg_idx = '0;
  logic [7:0] cfg_dur = '0;

  logic [1:0] a_phase, b_phase;
  logic [7:0] a_rem, b_rem;
  logic       a_busy, a_paused, a_pd, a_sd;
  logic       b_busy, b_paused, b_pd, b_sd;

  int total = 0;
  int bad   = 0;
  int pdcnt = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.LOOP(1'b0)) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .pause(pause), .skip(skip), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_dur(cfg_dur), .phase(a_phase), .remaining(a_rem),
    .busy(a_busy), .paused(a_paused), .phase_done(a_pd),
    .seq_done(a_sd)
  );

  phase_sequencer #(.LOOP(1'b1)) u_loop (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .pause(pause), .skip(skip), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_dur(cfg_dur), .phase(b_phase), .remaining(b_rem),
    .busy(b_busy), .paused(b_paused), .phase_done(b_pd),
    .seq_done(b_sd)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int ph, input int rm,
                       input int bz, input int pd, input int sd);
    chk({tag, ".phase"}, int'(a_phase), ph);
    chk({tag, ".rem"}, int'(a_rem), rm);
    chk({tag, ".busy"}, int'(a_busy), bz);
    chk({tag, ".pd"}, int'(a_pd), pd);
    chk({tag, ".sd"}, int'(a_sd), sd);
  endtask

  task automatic do_tick();
    tick = 1;
    step();
    tick = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
    step();
  endtask

  initial begin
    // reset state
    do_reset();
    chk_a("rst", 0, 0, 0, 0, 0);
    chk("rst.paused", int'(a_paused), 0);

    // 1: default durations, 8 ticks through 4 phases
    start = 1;
    step();
    start = 0;
    chk_a("t1.start", 0, 2, 1, 0, 0);
    pdcnt = 0;
    for (int k = 1; k <= 8; k++) begin
      do_tick();
      pdcnt += int'(a_pd);
      if (k == 8) chk_a("t1.end", 0, 0, 0, 1, 1);
      else if (k % 2 == 0) chk_a("t1.adv", k / 2, 2, 1, 1, 0);
      else chk_a("t1.cnt", (k - 1) / 2, 1, 1, 0, 0);
      step();
      pdcnt += int'(a_pd);
      chk("t1.gap.pd", int'(a_pd), 0);
    end
    chk("t1.pdcnt", pdcnt, 4);
    chk("t1.idle.busy", int'(a_busy), 0);

    // 2: dur[1]=5, dur[2]=0 (stored as 1)
    cfg_we = 1; cfg_idx = 2'd1; cfg_dur = 8'd5;
    step();
    cfg_idx = 2'd2; cfg_dur = 8'd0;
    step();
    cfg_we = 0;
    start = 1;
    step();
    start = 0;
    chk_a("t2.start", 0, 2, 1, 0, 0);
    do_tick();
    do_tick();
    chk_a("t2.ph1", 1, 5, 1, 1, 0);
    do_tick();
    do_tick();
    chk_a("t2.r3", 1, 3, 1, 0, 0);

    // 3: pause for 10 ticks at remaining 3, skip ignored
    pause = 1;
    step();
    chk("t3.paused", int'(a_paused), 1);
    chk("t3.busy", int'(a_busy), 1);
    for (int k = 0; k < 10; k++) begin
      tick = 1;
      skip = (k == 5);
      step();
    end
    tick = 0;
    skip = 0;
    chk_a("t3.hold", 1, 3, 1, 0, 0);
    chk("t3.hold.paused", int'(a_paused), 1);
    pause = 0;
    step();
    chk("t3.rel.paused", int'(a_paused), 0);
    chk_a("t3.rel", 1, 3, 1, 0, 0);
    do_tick();
    do_tick();
    chk_a("t3.r1", 1, 1, 1, 0, 0);
    do_tick();
    chk_a("t3.ph2", 2, 1, 1, 1, 0);
    do_tick();
    chk_a("t2.ph2end", 3, 2, 1, 1, 0);
    stop = 1;
    step();
    stop = 0;
    chk_a("t2.stop", 0, 0, 0, 0, 0);

    // 4: skip+tick same edge, then mid-phase write
    start = 1;
    step();
    start = 0;
    chk_a("t4.start", 0, 2, 1, 0, 0);
    skip = 1; tick = 1;
    step();
    skip = 0; tick = 0;
    pdcnt = int'(a_pd);
    chk_a("t4.skip", 1, 5, 1, 1, 0);
    cfg_we = 1; cfg_idx = 2'd1; cfg_dur = 8'd7;
    step();
    cfg_we = 0;
    pdcnt += int'(a_pd);
    chk("t4.pdcnt", pdcnt, 1);
    chk_a("t4.wr", 1, 5, 1, 0, 0);
    start = 1;
    step();
    start = 0;
    chk_a("t4.restart", 1, 5, 1, 0, 0);
    stop = 1; pause = 1;
    step();
    stop = 0; pause = 0;
    chk_a("t4.stop", 0, 0, 0, 0, 0);

    // 5: LOOP=1 instance with default durations
    do_reset();
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 8; k++) do_tick();
    chk("t5.sd", int'(b_sd), 1);
    chk("t5.pd", int'(b_pd), 1);
    chk("t5.phase", int'(b_phase), 0);
    chk("t5.rem", int'(b_rem), 2);
    chk("t5.busy", int'(b_busy), 1);
    chk("t5.a.busy", int'(a_busy), 0);
    stop = 1;
    step();
    stop = 0;
    chk("t5.stop.busy", int'(b_busy), 0);
    chk("t5.stop.rem", int'(b_rem), 0);
    chk("t5.stop.pd", int'(b_pd), 0);
    chk("t5.stop.sd", int'(b_sd), 0);

    // 6: async reset mid-run restores durations
    cfg_we = 1; cfg_idx = 2'd0; cfg_dur = 8'd9;
    step();
    cfg_idx = 2'd2; cfg_dur = 8'd6;
    step();
    cfg_we = 0;
    start = 1;
    step();
    start = 0;
    chk_a("t6.start", 0, 9, 1, 0, 0);
    skip = 1;
    step();
    step();
    skip = 0;
    chk_a("t6.ph2", 2, 6, 1, 1, 0);
    #3;
    rst = 1;
    #1;
    chk_a("t6.async", 0, 0, 0, 0, 0);
    chk("t6.async.paused", int'(a_paused), 0);
    step();
    rst = 0;
    start = 1;
    step();
    start = 0;
    chk_a("t6.dur0", 0, 2, 1, 0, 0);
    skip = 1;
    step();
    step();
    skip = 0;
    chk_a("t6.dur2", 2, 2, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
